// File: rtl/fm_mod_pkg.sv
// Shared defaults, state encoding and saturation limits for the FM NCO output stage.
package fm_mod_pkg;

  localparam int          ACC_W_D       = 32;
  localparam int          IN_W_D        = 24;
  localparam logic [31:0] CARRIER_INC_D = 32'h1999_999A;
  localparam int          DEV_SHIFT_D   = 4;
  localparam int          WDOG_D        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } st_e;

  // Largest legal increment for a w-bit accumulator: keeps the carrier below Nyquist.
  function automatic logic [63:0] freq_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  localparam logic [63:0] FREQ_MAX = freq_max(ACC_W_D);
  localparam logic [63:0] FREQ_MIN = 64'd0;

endpackage

// File: rtl/fm_nco_out_acc.sv
// Free-running phase accumulator; the registered MSB is the square-wave carrier.
module nco_phase_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [ACC_W-1:0] freq_word,
  output logic             o_msb,
  output logic [ACC_W-1:0] o_acc
);

  logic [ACC_W-1:0] r_acc;
  logic             r_msb;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_msb <= 1'b0;
    end else if (!enable) begin
      r_acc <= '0;
      r_msb <= 1'b0;
    end else begin
      r_acc <= r_acc + freq_word;
      r_msb <= r_acc[ACC_W-1];
    end
  end

  assign o_msb = r_msb;
  assign o_acc = r_acc;

endmodule

// File: rtl/fm_nco_out.sv
// FM output stage: captures deviation samples, applies them on the 192 kHz grid,
// saturates the resulting increment and falls back to the bare carrier on starvation.
module fm_nco_out
  import fm_mod_pkg::*;
#(
  parameter int               ACC_W       = ACC_W_D,
  parameter int               IN_W        = IN_W_D,
  parameter logic [ACC_W-1:0] CARRIER_INC = CARRIER_INC_D,
  parameter int               DEV_SHIFT   = DEV_SHIFT_D,
  parameter int               WDOG        = WDOG_D
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clken192kHz,
  input  logic [IN_W-1:0]  fm_in,
  input  logic             fm_valid,
  input  logic             enable,
  output logic             Fmout,
  output logic [ACC_W-1:0] freq_word,
  output logic             underrun
);

  // Sum width covers the shifted deviation plus carrier with headroom for sign and carry.
  localparam int SW = ((IN_W + DEV_SHIFT > ACC_W) ? IN_W + DEV_SHIFT : ACC_W) + 2;
  localparam int MW = $clog2(WDOG + 1);
  localparam logic [ACC_W-1:0] F_MAX = ACC_W'(freq_max(ACC_W));
  localparam logic [ACC_W-1:0] F_MIN = ACC_W'(FREQ_MIN);

  st_e              r_state, w_state_nxt;
  logic [IN_W-1:0]  r_pend;
  logic             r_pend_flag;
  logic [MW-1:0]    r_miss, w_miss_inc;
  logic [ACC_W-1:0] r_freq;
  logic             r_underrun;

  logic signed [SW-1:0] w_dev, w_sum;
  logic [ACC_W-1:0]     w_sat;
  logic                 w_tick, w_apply, w_miss, w_expire, w_acc_en;
  logic [ACC_W-1:0]     w_acc;

  assign w_dev = $signed({{(SW-IN_W){r_pend[IN_W-1]}}, r_pend}) <<< DEV_SHIFT;
  assign w_sum = $signed({{(SW-ACC_W){1'b0}}, CARRIER_INC}) + w_dev;

  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum[SW-1])
      w_sat = F_MIN;
    else if (|w_sum[SW-2:ACC_W-1])
      w_sat = F_MAX;
  end

  // Disable takes priority over an apply point landing on the same cycle.
  assign w_tick     = enable && (r_state != ST_IDLE) && clken192kHz;
  assign w_apply    = w_tick && r_pend_flag;
  assign w_miss     = w_tick && !r_pend_flag;
  assign w_miss_inc = (r_miss == MW'(WDOG)) ? r_miss : r_miss + 1'b1;
  assign w_expire   = w_miss && (w_miss_inc == MW'(WDOG));
  assign w_acc_en   = enable && (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_RUN;
        ST_RUN:  if (w_expire) w_state_nxt = ST_HOLD;
        ST_HOLD: if (w_apply)  w_state_nxt = ST_RUN;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A fresh strobe wins over the clear, so a coincident apply leaves the new sample pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend      <= '0;
      r_pend_flag <= 1'b0;
    end else if (fm_valid) begin
      r_pend      <= fm_in;
      r_pend_flag <= 1'b1;
    end else if (w_apply) begin
      r_pend_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_miss     <= '0;
      r_underrun <= 1'b0;
    end else if (!enable || w_apply) begin
      r_miss     <= '0;
      r_underrun <= 1'b0;
    end else if (w_miss) begin
      r_miss <= w_miss_inc;
      if (w_expire) r_underrun <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        r_freq <= CARRIER_INC;
    else if (w_apply)  r_freq <= w_sat;
    else if (w_expire) r_freq <= CARRIER_INC;
  end

  nco_phase_acc #(.ACC_W(ACC_W)) u_acc (
    .clock     (clock),
    .reset     (reset),
    .enable    (w_acc_en),
    .freq_word (r_freq),
    .o_msb     (Fmout),
    .o_acc     (w_acc)
  );

  assign freq_word = r_freq;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_fm_nco_out.sv
// Directed bench: three parameterisations share one stimulus stream.
module tb_fm_nco_out;

  logic        clock, reset, clken, fm_valid, enable;
  logic [23:0] fm_in;
  logic        f0, f1, f2, u0, u1, u2;
  logic [31:0] w0, w1, w2;
  int          n_err = 0;
  int          n_chk = 0;

  fm_nco_out dut0 (
    .clock(clock), .reset(reset), .clken192kHz(clken), .fm_in(fm_in), .fm_valid(fm_valid),
    .enable(enable), .Fmout(f0), .freq_word(w0), .underrun(u0));

  fm_nco_out #(.CARRIER_INC(32'h4000_0000)) dut1 (
    .clock(clock), .reset(reset), .clken192kHz(clken), .fm_in(fm_in), .fm_valid(fm_valid),
    .enable(enable), .Fmout(f1), .freq_word(w1), .underrun(u1));

  fm_nco_out #(.DEV_SHIFT(8)) dut2 (
    .clock(clock), .reset(reset), .clken192kHz(clken), .fm_in(fm_in), .fm_valid(fm_valid),
    .enable(enable), .Fmout(f2), .freq_word(w2), .underrun(u2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_valid(input logic [23:0] v);
    fm_in = v; fm_valid = 1'b1;
    tick();
    fm_valid = 1'b0;
  endtask

  task automatic pulse_clken();
    clken = 1'b1;
    tick();
    clken = 1'b0;
  endtask

  initial begin
    logic        any_hi;
    logic [31:0] a_prev, p;
    reset = 1'b0; enable = 1'b0; clken = 1'b0; fm_valid = 1'b0; fm_in = '0;
    repeat (3) tick();
    chk("rst_fmout", 32'({f0, f1, f2}), 32'd0);
    chk("rst_freq0", w0, 32'h1999_999A);
    chk("rst_freq1", w1, 32'h4000_0000);
    chk("rst_under", 32'({u0, u1, u2}), 32'd0);
    chk("rst_acc1",  dut1.u_acc.o_acc, 32'd0);

    reset = 1'b1;
    any_hi = 1'b0;
    repeat (1000) begin
      tick();
      any_hi = any_hi | f0 | f1 | f2;
    end
    chk("idle_fmout", 32'(any_hi), 32'd0);
    chk("idle_freq0", w0, 32'h1999_999A);

    // Phase pattern on the quarter-rate carrier
    enable = 1'b1;
    tick();
    chk("ph_acc0", dut1.u_acc.o_acc, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      p = 32'(k - 1) * 32'h4000_0000;
      chk("ph_acc", dut1.u_acc.o_acc, 32'(k) * 32'h4000_0000);
      chk("ph_fmout", 32'(f1), 32'(p[31]));
    end

    // Basic apply, ten cycles between strobe and clken
    pulse_valid(24'h000100);
    repeat (9) tick();
    chk("ap_before", w0, 32'h1999_999A);
    pulse_clken();
    chk("ap_freq0", w0, 32'h1999_A99A);
    chk("ap_freq1", w1, 32'h4000_1000);
    chk("ap_freq2", w2, 32'h199A_999A);
    a_prev = dut1.u_acc.o_acc;
    tick();
    chk("ap_step1", dut1.u_acc.o_acc - a_prev, 32'h4000_1000);

    // Saturation
    pulse_valid(24'h7FFFFF);
    pulse_clken();
    chk("sat_hi2", w2, 32'h7FFF_FFFF);
    chk("sat_hi0", w0, 32'h2199_998A);
    pulse_valid(24'h800000);
    pulse_clken();
    chk("sat_lo2", w2, 32'h0000_0000);
    chk("sat_lo0", w0, 32'h1199_999A);

    // Watchdog
    for (int k = 1; k <= 4; k++) begin
      tick(); tick();
      pulse_clken();
      if (k == 3) begin
        chk("wd3_under", 32'(u0), 32'd0);
        chk("wd3_freq0", w0, 32'h1199_999A);
      end
    end
    chk("wd4_under", 32'({u0, u1, u2}), 32'b111);
    chk("wd4_freq0", w0, 32'h1999_999A);
    chk("wd4_freq2", w2, 32'h1999_999A);
    pulse_valid(24'h000010);
    pulse_clken();
    chk("wd_rec_freq0", w0, 32'h1999_9A9A);
    chk("wd_rec_freq2", w2, 32'h1999_A99A);
    chk("wd_rec_under", 32'({u0, u1, u2}), 32'd0);

    // Coincident strobe and clken
    pulse_valid(24'h000002);
    fm_in = 24'h000001; fm_valid = 1'b1; clken = 1'b1;
    tick();
    fm_valid = 1'b0; clken = 1'b0;
    chk("sim_old0", w0, 32'h1999_99BA);
    chk("sim_old2", w2, 32'h1999_9B9A);
    tick();
    pulse_clken();
    chk("sim_new0", w0, 32'h1999_99AA);
    chk("sim_new2", w2, 32'h1999_9A9A);
    pulse_clken();
    chk("sim_miss0", w0, 32'h1999_99AA);

    // Asynchronous reset mid-run with a sample pending
    pulse_valid(24'h000100);
    pulse_clken();
    chk("pre_rst0", w0, 32'h1999_A99A);
    pulse_valid(24'h000200);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_freq0", w0, 32'h1999_999A);
    chk("ar_freq1", w1, 32'h4000_0000);
    chk("ar_fmout", 32'({f0, f1, f2}), 32'd0);
    chk("ar_under", 32'({u0, u1, u2}), 32'd0);
    chk("ar_acc1",  dut1.u_acc.o_acc, 32'd0);
    tick(); tick();
    reset = 1'b1;
    repeat (3) tick();
    pulse_clken();
    chk("post_rst_nopend", w0, 32'h1999_999A);
    chk("post_rst_under", 32'(u0), 32'd0);

    // Three more misses reach the watchdog; disable then clears underrun
    repeat (3) begin
      tick();
      pulse_clken();
    end
    chk("wd2_under", 32'(u0), 32'd1);
    enable = 1'b0;
    tick();
    chk("dis_under", 32'({u0, u1, u2}), 32'd0);
    chk("dis_acc1", dut1.u_acc.o_acc, 32'd0);
    chk("dis_fmout", 32'({f0, f1, f2}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
